// File: rtl/phase_3b_derotate_pkg.sv
// Shared types and helpers for the 3-bit phase de-rotator.
// Holds the FSM state type, the default sync pattern and a reference left rotation.
package phase_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        HUNT,
        PASS
    } state_e;

    localparam int unsigned BITSTREAM_DEF = 64;
    localparam logic [63:0] SYNC_WORD_DEF = 64'hF0E1_D2C3_B4A5_9687;

    // Inverse of the transmit-side right rotation by k.
    function automatic logic [63:0] rotl(input logic [63:0] x, input logic [2:0] k);
        logic [63:0] y;
        y = x;
        if (k != 3'd0) begin
            y = (x << k) | (x >> (7'd64 - {4'd0, k}));
        end
        return y;
    endfunction

endpackage

// File: rtl/phase_3b_derotate_if.sv
// Streaming bus for the de-rotator: rotated words in, recovered payload words out.
// master drives the input side and consumes the output side; slave is the block.
interface phase_3b_derotate_if #(
    parameter int unsigned W = 64
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_bits;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_bits;
    logic         out_last;

    modport master (
        output in_valid, in_bits, out_ready,
        input  in_ready, out_valid, out_bits, out_last
    );

    modport slave (
        input  in_valid, in_bits, out_ready,
        output in_ready, out_valid, out_bits, out_last
    );

endinterface

// File: rtl/phase_3b_derotate_rotl.sv
// Combinational left rotator by a 3-bit amount.
module phase_3b_rotl
    import phase_pkg::*;
#(
    parameter int unsigned BITSTREAM = BITSTREAM_DEF
) (
    input  logic [BITSTREAM-1:0] x_i,
    input  logic [2:0]           k_i,
    output logic [BITSTREAM-1:0] y_o
);

    always_comb begin
        y_o = x_i;
        if (k_i != 3'd0) begin
            y_o = (x_i << k_i) | (x_i >> (BITSTREAM - 32'(k_i)));
        end
    end

endmodule

// File: rtl/phase_3b_derotate.sv
// Receive-side phase de-rotator: hunts the sync word to recover the rotation k,
// then left-rotates each payload beat of the frame through a single output register.
module phase_3b_derotate
    import phase_pkg::*;
#(
    parameter int unsigned          BITSTREAM = BITSTREAM_DEF,
    parameter logic [BITSTREAM-1:0] SYNC_WORD = BITSTREAM'(SYNC_WORD_DEF),
    parameter int unsigned          FRAME_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    phase_3b_derotate_if.slave   bus,
    output logic [2:0]           k_found,
    output logic                 locked,
    output logic                 sync_err
);

    localparam int unsigned     CW        = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0]   LAST_BEAT = CW'(FRAME_LEN - 1);

    state_e                 state_q;
    logic [2:0]             cand_q;
    logic [BITSTREAM-1:0]   cap_q;
    logic [2:0]             k_q;
    logic [CW-1:0]          cnt_q;
    logic                   ov_q;
    logic [BITSTREAM-1:0]   ob_q;
    logic                   ol_q;
    logic                   err_q;
    logic                   rdy_en_q;

    logic [BITSTREAM-1:0]   hunt_rot;
    logic [BITSTREAM-1:0]   pay_rot;
    logic                   in_ready;
    logic                   in_xfer;
    logic                   out_xfer;

    phase_3b_rotl #(.BITSTREAM(BITSTREAM)) u_rotl_hunt (
        .x_i (cap_q),
        .k_i (cand_q),
        .y_o (hunt_rot)
    );

    phase_3b_rotl #(.BITSTREAM(BITSTREAM)) u_rotl_pay (
        .x_i (bus.in_bits),
        .k_i (k_q),
        .y_o (pay_rot)
    );

    // rdy_en_q keeps in_ready low while reset is asserted; the output register
    // must be empty or draining before any new word (sync or payload) is taken.
    always_comb begin
        in_ready = rdy_en_q & (state_q != HUNT) & (~ov_q | bus.out_ready);
        in_xfer  = bus.in_valid & in_ready;
        out_xfer = ov_q & bus.out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            cand_q   <= '0;
            cap_q    <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            ov_q     <= 1'b0;
            ob_q     <= '0;
            ol_q     <= 1'b0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            err_q    <= 1'b0;
            if (out_xfer) begin
                ov_q <= 1'b0;
                ol_q <= 1'b0;
            end
            case (state_q)
                SEARCH: begin
                    if (in_xfer) begin
                        cap_q   <= bus.in_bits;
                        cand_q  <= '0;
                        state_q <= HUNT;
                    end
                end
                HUNT: begin
                    if (hunt_rot == SYNC_WORD) begin
                        k_q     <= cand_q;
                        cnt_q   <= '0;
                        state_q <= PASS;
                    end else if (cand_q == 3'd7) begin
                        err_q   <= 1'b1;
                        state_q <= SEARCH;
                    end else begin
                        cand_q <= cand_q + 3'd1;
                    end
                end
                PASS: begin
                    // A new load overrides the drain clear above, so a simultaneous
                    // in/out transfer keeps out_valid high.
                    if (in_xfer) begin
                        ob_q <= pay_rot;
                        ov_q <= 1'b1;
                        ol_q <= (cnt_q == LAST_BEAT);
                        if (cnt_q == LAST_BEAT) begin
                            cnt_q   <= '0;
                            state_q <= SEARCH;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= SEARCH;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = ov_q;
    assign bus.out_bits  = ob_q;
    assign bus.out_last  = ol_q;
    assign k_found       = k_q;
    assign locked        = (state_q == PASS);
    assign sync_err      = err_q;

endmodule

// File: tb/tb_phase_3b_derotate.sv
// Self-checking bench for phase_3b_derotate: table of hunt/frame cases, randomized
// frames under random backpressure, and a mid-frame reset, all scored against a queue model.
module tb_phase_3b_derotate;

    localparam logic [63:0] SYNC = 64'hF0E1_D2C3_B4A5_9687;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] k_found;
    logic       locked;
    logic       sync_err;

    always #5 clk = ~clk;

    phase_3b_derotate_if #(.W(64)) bus ();

    phase_3b_derotate #(
        .BITSTREAM (64),
        .SYNC_WORD (SYNC),
        .FRAME_LEN (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .k_found  (k_found),
        .locked   (locked),
        .sync_err (sync_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: expected {last, original payload} in delivery order.
    logic [64:0] exp_q[$];
    logic [64:0] mon_e;
    logic [63:0] hold_bits;
    logic        hold_last;
    bit          held   = 1'b0;
    bit          mon_en = 1'b1;
    int          rmode  = 0;
    int          last_k = 0;

    typedef struct {
        logic [63:0] sync;
        bit          hit;
        int          k;
        int          lat;
        bit          b2b;
        int          hold_at;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Transmit-side rotation: result bit i comes from source bit (i+k) mod 64.
    function automatic logic [63:0] rotr(input logic [63:0] x, input int k);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[i] = x[(i + k) % 64];
        return y;
    endfunction

    always @(posedge clk) begin
        #2;
        if (rmode == 0)      bus.out_ready = 1'b1;
        else if (rmode == 1) bus.out_ready = 1'($urandom_range(1));
        else                 bus.out_ready = 1'b0;
    end

    always @(negedge clk) begin
        if (!mon_en) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk1("bp_valid_stable", bus.out_valid, 1'b1);
                chk("bp_bits_stable", bus.out_bits, hold_bits);
                chk1("bp_last_stable", bus.out_last, hold_last);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h expected no output", bus.out_bits);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_bits", bus.out_bits, mon_e[63:0]);
                    chk1("out_last", bus.out_last, mon_e[64]);
                end
            end
            held      = bus.out_valid && !bus.out_ready;
            hold_bits = bus.out_bits;
            hold_last = bus.out_last;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_word(input logic [63:0] w, input bit gaps);
        bit ok;
        int t;
        if (gaps && $urandom_range(3) == 0) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.in_bits  = w;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        t  = 0;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        chk1("send_accepted", ok, 1'b1);
    endtask

    task automatic do_hold(input logic [63:0] w);
        bus.in_bits  = w;
        bus.in_valid = 1'b1;
        rmode = 2;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk1("bp_in_ready_low", bus.in_ready, 1'b0);
            chk1("bp_out_valid_high", bus.out_valid, 1'b1);
            @(posedge clk);
            #1;
        end
        rmode = 0;
    endtask

    task automatic run_frame(input logic [63:0] sync, input bit hit, input int k, input int lat,
                             input bit keep_valid, input bit gaps, input int hold_at,
                             input int nbeats, input bit first_one);
        int n;
        logic [63:0] p;
        send_word(sync, 1'b0);
        chk1("hunt_in_ready_low", bus.in_ready, 1'b0);
        n = 0;
        while (!locked && !sync_err && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("hunt_latency", 64'(n), 64'(lat));
        if (!hit) begin
            bus.in_valid = 1'b0;
            chk1("miss_sync_err", sync_err, 1'b1);
            chk1("miss_unlocked", locked, 1'b0);
            chk("miss_k_held", 64'(k_found), 64'(last_k));
            @(posedge clk);
            #1;
            chk1("sync_err_one_cycle", sync_err, 1'b0);
            chk1("miss_still_unlocked", locked, 1'b0);
            return;
        end
        chk1("hit_locked", locked, 1'b1);
        chk("hit_k_found", 64'(k_found), 64'(k));
        last_k = k;
        for (int b = 0; b < nbeats; b++) begin
            p = (first_one && b == 0) ? 64'h1 : {$urandom, $urandom};
            exp_q.push_back({(b == 15), p});
            if (b == hold_at) do_hold(rotr(p, k));
            send_word(rotr(p, k), gaps);
        end
        if (nbeats == 16) begin
            chk1("frame_end_unlocked", locked, 1'b0);
            chk("frame_end_k_held", 64'(k_found), 64'(k));
        end
        if (!keep_valid) bus.in_valid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk1({tag, "_in_ready"}, bus.in_ready, 1'b0);
        chk1({tag, "_out_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_out_bits"}, bus.out_bits, 64'h0);
        chk1({tag, "_out_last"}, bus.out_last, 1'b0);
        chk({tag, "_k_found"}, 64'(k_found), 64'h0);
        chk1({tag, "_locked"}, locked, 1'b0);
        chk1({tag, "_sync_err"}, sync_err, 1'b0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{rotr(SYNC, 3), 1'b1, 3, 4, 1'b0, -1};
        tbl[1] = '{SYNC,          1'b1, 0, 1, 1'b0, -1};
        tbl[2] = '{64'h0,         1'b0, 0, 8, 1'b0, -1};
        tbl[3] = '{rotr(SYNC, 5), 1'b1, 5, 6, 1'b0, -1};
        tbl[4] = '{rotr(SYNC, 4), 1'b1, 4, 5, 1'b0, 6};
        tbl[5] = '{rotr(SYNC, 7), 1'b1, 7, 8, 1'b1, -1};
        tbl[6] = '{rotr(SYNC, 2), 1'b1, 2, 3, 1'b0, -1};
        tbl[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 8, 1'b0, -1};

        bus.in_valid  = 1'b0;
        bus.in_bits   = '0;
        bus.out_ready = 1'b1;
        #1;
        chk_reset("init");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].sync, tbl[i].hit, tbl[i].k, tbl[i].lat, tbl[i].b2b,
                      1'b0, tbl[i].hold_at, 16, (i == 0));
            if (tbl[i].hit && !tbl[i].b2b) begin
                repeat (2) @(posedge clk);
                #1;
                chk("idle_k_held", 64'(k_found), 64'(tbl[i].k));
            end
        end
        drain();

        rmode = 1;
        for (int f = 0; f < 3; f++) begin
            int k;
            k = $urandom_range(7);
            run_frame(rotr(SYNC, k), 1'b1, k, k + 1, (f < 2), 1'b1, -1, 16, 1'b0);
        end
        rmode = 0;
        drain();

        run_frame(rotr(SYNC, 6), 1'b1, 6, 7, 1'b1, 1'b0, -1, 8, 1'b0);
        #1;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        chk_reset("mid_reset");
        exp_q.delete();
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        last_k = 0;
        run_frame(rotr(SYNC, 6), 1'b1, 6, 7, 1'b0, 1'b0, -1, 16, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_3b_derotate.md
Name: phase_3b_derotate

Overview:
- Receive-side counterpart of the 3-bit phase rotator, which rotates a bitstream right by k (0..7).
- Consumes framed, rotated bitstream words and recovers the unknown k by hunting a known sync word.
- Left-rotates each payload word by the recovered k, restoring the original bitstream for downstream stochastic-compute stages.
- Streaming valid/ready on both sides; one frame = 1 sync beat followed by FRAME_LEN payload beats.

Parameters:
- BITSTREAM, 64, width of each bitstream word.
- SYNC_WORD, 64'hF0E1_D2C3_B4A5_9687, unrotated sync pattern. It must have no rotational self-match for shifts 1..7.
- FRAME_LEN, 16, payload beats per frame; must be ≥1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts the input word.
- in_bits  in  BITSTREAM  rotated input word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output word.
- out_bits  out  BITSTREAM  de-rotated payload word.
- out_last  out  1  marks the final payload beat of a frame.
- k_found  out  3  recovered phase of the current frame.
- locked  out  1  high while in PASS.
- sync_err  out  1  one-cycle pulse when a hunt fails.

Behaviour:
- Reset (async assert, sync release) clears everything: state=SEARCH; all outputs 0 (in_ready, out_valid, out_bits, out_last, k_found, locked, sync_err); beat counter 0; capture register 0.
- Transfer rule: a transfer occurs on a clock edge where valid & ready are both high. in_ready never depends combinationally on in_valid.
- rotl(x,k) = (x<<k)|(x>>(BITSTREAM-k)) for k≠0; rotl(x,0) = x. It is the exact inverse of the transmit-side right rotation.
- SEARCH:
  - in_ready=1.
  - On transfer: capture in_bits, set candidate=0, go to HUNT.
- HUNT:
  - in_ready=0; one candidate tested per cycle.
  - If rotl(cap,candidate)==SYNC_WORD: k_found<=candidate, go to PASS with beat counter=0.
  - Else if candidate==7: pulse sync_err for 1 cycle, discard the word, go to SEARCH.
  - Else candidate++.
  - Hunt latency is k+1 cycles on a hit; a miss takes 8 cycles. The lowest matching k wins.
- PASS:
  - locked=1.
  - The output stage is a single register: in_ready = !out_valid | out_ready.
  - On input transfer: out_bits<=rotl(in_bits,k_found); out_valid<=1; out_last<=(count==FRAME_LEN-1); count++.
  - Output transfer without a new input transfer: out_valid<=0, out_last<=0.
  - After the input transfer of the last payload beat, go to SEARCH. The last beat stays in the output register until it is taken, so out_valid may still be high in SEARCH.
  - In SEARCH, in_ready=1 only when the output register is empty or draining: !out_valid | out_ready.
- Backpressure: out_bits, out_last and out_valid hold stable while out_valid & !out_ready. No data is lost or duplicated.
- Input-side latency: 1 cycle from in transfer to out_valid.
- k_found holds its value after a frame ends and only changes on the next successful hunt.
- Simultaneous input and output transfer in PASS loads the new word; out_valid stays 1.
- Reset mid-frame aborts immediately. Partial output is dropped and the next word is treated as a sync beat.

Decomposition:
- Package phase_pkg:
  - state enum {SEARCH, HUNT, PASS};
  - default SYNC_WORD constant;
  - rotl function (shared with testbench models).
- Sub-module phase_3b_rotl: combinational left rotator (BITSTREAM, 3-bit k). It is instanced twice:
  - once for the hunt compare;
  - once for the payload path.

Test Plan:
1. Sync = rotr(SYNC_WORD,3), then payload 64'h2000_0000_0000_0000 → k_found=3 after 4 HUNT cycles, locked=1, out_bits=64'h1.
2. k=0 frame: sync = SYNC_WORD unchanged → HUNT hits in 1 cycle. 16 random payloads pass unchanged; out_last is high only on beat 16.
3. Sync beat 64'h0 → 8 HUNT cycles, sync_err pulses once, state returns to SEARCH. A following valid sync with k=5 locks with k_found=5.
4. Backpressure: hold out_ready=0 for 5 cycles mid-frame → in_ready=0 and out_bits stable. On release, all 16 payloads are delivered in order with no gaps or duplicates.
5. Back-to-back frames k=7 then k=2 with continuous in_valid → each payload equals rotl(in,k) for its own frame; out_last appears every 16th beat.
6. Assert rst_n low at payload beat 8 → all outputs are 0 at once. After release, a new frame (k=6) decodes correctly.
